// File: rtl/vga_sync_gen.sv
// 640x480@60 VGA timing generator: pixel tick, coordinates, sync pins and a frame strobe.
// Optional VGA_BLINK_EN adds a ~0.5 s blink output derived from a 30-frame counter.
module vga_sync_gen #(
  parameter int unsigned H_DISPLAY = 640,
  parameter int unsigned H_FRONT   = 16,
  parameter int unsigned H_SYNC    = 96,
  parameter int unsigned H_BACK    = 48,
  parameter int unsigned V_DISPLAY = 480,
  parameter int unsigned V_FRONT   = 10,
  parameter int unsigned V_SYNC    = 2,
  parameter int unsigned V_BACK    = 33,
  parameter int unsigned TICK_DIV  = 4
) (
  input  logic       clk,
  input  logic       reset,
  output logic       p_tick,
  output logic [9:0] pix_x,
  output logic [9:0] pix_y,
  output logic       video_on,
  output logic       hsync,
  output logic       vsync,
`ifdef VGA_BLINK_EN
  output logic       blink,
`endif
  output logic       frame_start
);

  localparam int unsigned CNT_W    = 10;
  localparam int unsigned H_TOTAL  = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL  = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
  localparam int unsigned HS_START = H_DISPLAY + H_FRONT;
  localparam int unsigned HS_END   = HS_START + H_SYNC - 1;
  localparam int unsigned VS_START = V_DISPLAY + V_FRONT;
  localparam int unsigned VS_END   = VS_START + V_SYNC - 1;
  localparam int unsigned DIV_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [DIV_W-1:0] r_div;
  logic [CNT_W-1:0] r_x;
  logic [CNT_W-1:0] r_y;
  logic             r_tick;
  logic             r_video_on;
  logic             r_hsync;
  logic             r_vsync;
  logic             r_frame_start;

  logic             w_tick;
  logic             w_h_end;
  logic             w_v_end;
  logic             w_frame_wrap;
  logic [DIV_W-1:0] w_div_nxt;
  logic [CNT_W-1:0] w_x_nxt;
  logic [CNT_W-1:0] w_y_nxt;

  assign w_tick       = (r_div == DIV_W'(TICK_DIV - 1));
  assign w_h_end      = (r_x == CNT_W'(H_TOTAL - 1));
  assign w_v_end      = (r_y == CNT_W'(V_TOTAL - 1));
  assign w_frame_wrap = w_tick & w_h_end & w_v_end;

  // Next divider and coordinate values; decodes are taken from these so they align with the counters.
  always_comb begin
    w_div_nxt = r_div + DIV_W'(1);
    w_x_nxt   = r_x;
    w_y_nxt   = r_y;
    if (w_tick) begin
      w_div_nxt = '0;
      if (w_h_end) begin
        w_x_nxt = '0;
        w_y_nxt = w_v_end ? '0 : r_y + CNT_W'(1);
      end else begin
        w_x_nxt = r_x + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_div         <= '0;
      r_x           <= '0;
      r_y           <= '0;
      r_tick        <= 1'b0;
      r_video_on    <= 1'b1;
      r_hsync       <= 1'b1;
      r_vsync       <= 1'b1;
      r_frame_start <= 1'b0;
    end else begin
      r_div         <= w_div_nxt;
      r_x           <= w_x_nxt;
      r_y           <= w_y_nxt;
      r_tick        <= w_tick;
      r_video_on    <= (w_x_nxt < CNT_W'(H_DISPLAY)) && (w_y_nxt < CNT_W'(V_DISPLAY));
      r_hsync       <= !((w_x_nxt >= CNT_W'(HS_START)) && (w_x_nxt <= CNT_W'(HS_END)));
      r_vsync       <= !((w_y_nxt >= CNT_W'(VS_START)) && (w_y_nxt <= CNT_W'(VS_END)));
      r_frame_start <= w_frame_wrap;
    end
  end

`ifdef VGA_BLINK_EN
  localparam int unsigned FCNT_W    = 5;
  localparam int unsigned BLINK_FRM = 30;

  logic [FCNT_W-1:0] r_fcnt;
  logic              r_blink;

  // Blink half period is BLINK_FRM frames.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_fcnt  <= '0;
      r_blink <= 1'b0;
    end else if (w_frame_wrap) begin
      if (r_fcnt == FCNT_W'(BLINK_FRM - 1)) begin
        r_fcnt  <= '0;
        r_blink <= ~r_blink;
      end else begin
        r_fcnt <= r_fcnt + FCNT_W'(1);
      end
    end
  end

  assign blink = r_blink;
`endif

  assign p_tick      = r_tick;
  assign pix_x       = r_x;
  assign pix_y       = r_y;
  assign video_on    = r_video_on;
  assign hsync       = r_hsync;
  assign vsync       = r_vsync;
  assign frame_start = r_frame_start;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Scoreboard bench for vga_sync_gen: full-size timing over the first lines, and a
// shrunk-timing instance for whole-frame, mid-frame reset and blink behaviour.
module tb_vga_sync_gen;

  typedef struct packed {
    logic       pt;
    logic [9:0] x;
    logic [9:0] y;
    logic       vo;
    logic       hs;
    logic       vs;
    logic       fs;
    logic       bl;
  } obs_t;

  localparam obs_t RST_OBS = '{1'b0, 10'd0, 10'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};

  logic clk;
  logic rst_n;
  logic mon_on;

  logic       d_pt, d_vo, d_hs, d_vs, d_fs;
  logic [9:0] d_x, d_y;
  logic       s_pt, s_vo, s_hs, s_vs, s_fs;
  logic [9:0] s_x, s_y;
  logic       d_bl, s_bl;

  int n_chk;
  int n_fail;
  int cnt_d, cnt_s;
  obs_t cur_d, cur_s;
  obs_t q_d[$];
  obs_t q_s[$];

  vga_sync_gen u_dut (
    .clk(clk), .reset(rst_n), .p_tick(d_pt), .pix_x(d_x), .pix_y(d_y),
    .video_on(d_vo), .hsync(d_hs), .vsync(d_vs),
`ifdef VGA_BLINK_EN
    .blink(d_bl),
`endif
    .frame_start(d_fs)
  );

  vga_sync_gen #(
    .H_DISPLAY(16), .H_FRONT(2), .H_SYNC(4), .H_BACK(3),
    .V_DISPLAY(10), .V_FRONT(2), .V_SYNC(2), .V_BACK(3),
    .TICK_DIV(2)
  ) u_small (
    .clk(clk), .reset(rst_n), .p_tick(s_pt), .pix_x(s_x), .pix_y(s_y),
    .video_on(s_vo), .hsync(s_hs), .vsync(s_vs),
`ifdef VGA_BLINK_EN
    .blink(s_bl),
`endif
    .frame_start(s_fs)
  );

`ifndef VGA_BLINK_EN
  assign d_bl = 1'b0;
  assign s_bl = 1'b0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected presentation after pixel tick k (k ticks since reset release).
  function automatic obs_t model(int k, int ht, int vt, int hd, int vd,
                                 int hs0, int hs1, int vs0, int vs1);
    obs_t m;
    int x, y, f;
    x = k % ht;
    y = (k / ht) % vt;
    f = k / (ht * vt);
    m.pt = 1'b1;
    m.x  = 10'(x);
    m.y  = 10'(y);
    m.vo = (x < hd) && (y < vd);
    m.hs = !((x >= hs0) && (x <= hs1));
    m.vs = !((y >= vs0) && (y <= vs1));
    m.fs = (k % (ht * vt)) == 0;
`ifdef VGA_BLINK_EN
    m.bl = ((f / 30) % 2) == 1;
`else
    m.bl = 1'b0;
`endif
    return m;
  endfunction

  function automatic obs_t model_d(int k);
    return model(k, 800, 525, 640, 480, 656, 751, 490, 491);
  endfunction

  function automatic obs_t model_s(int k);
    return model(k, 25, 17, 16, 10, 18, 21, 12, 13);
  endfunction

  function automatic obs_t get_d();
    return '{d_pt, d_x, d_y, d_vo, d_hs, d_vs, d_fs, d_bl};
  endfunction

  function automatic obs_t get_s();
    return '{s_pt, s_x, s_y, s_vo, s_hs, s_vs, s_fs, s_bl};
  endfunction

  task automatic chk(input string nm, input obs_t act, input obs_t exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s t=%0t got pt=%b x=%0d y=%0d von=%b hs=%b vs=%b fs=%b bl=%b want pt=%b x=%0d y=%0d von=%b hs=%b vs=%b fs=%b bl=%b",
               nm, $time, act.pt, act.x, act.y, act.vo, act.hs, act.vs, act.fs, act.bl,
               exp.pt, exp.x, exp.y, exp.vo, exp.hs, exp.vs, exp.fs, exp.bl);
    end
  endtask

  task automatic chk_int(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s t=%0t got %0d want %0d", nm, $time, act, exp);
    end
  endtask

  // Monitor for the full-size instance: pops an expectation on every DUT pixel tick.
  always @(posedge clk) begin
    obs_t e;
    #1;
    if (mon_on) begin
      if (!rst_n) begin
        cnt_d = 0;
        cur_d = RST_OBS;
        chk("full_reset", get_d(), RST_OBS);
      end else begin
        cnt_d++;
        if (d_pt) begin
          if (q_d.size() == 0) chk_int("full_underflow", 0, 1);
          else cur_d = q_d.pop_front();
        end
        e    = cur_d;
        e.pt = (cnt_d % 4) == 0;
        e.fs = cur_d.fs & e.pt;
        chk("full_run", get_d(), e);
      end
    end
  end

  // Monitor for the shrunk-timing instance.
  always @(posedge clk) begin
    obs_t e;
    #1;
    if (mon_on) begin
      if (!rst_n) begin
        cnt_s = 0;
        cur_s = RST_OBS;
        chk("small_reset", get_s(), RST_OBS);
      end else begin
        cnt_s++;
        if (s_pt) begin
          if (q_s.size() == 0) chk_int("small_underflow", 0, 1);
          else cur_s = q_s.pop_front();
        end
        e    = cur_s;
        e.pt = (cnt_s % 2) == 0;
        e.fs = cur_s.fs & e.pt;
        chk("small_run", get_s(), e);
      end
    end
  end

  initial begin
    n_chk  = 0;
    n_fail = 0;
    cnt_d  = 0;
    cnt_s  = 0;
    cur_d  = RST_OBS;
    cur_s  = RST_OBS;
    rst_n  = 1'b0;
    mon_on = 1'b1;
    repeat (10) @(posedge clk);

    // Run 1: full instance reaches (300,1), small instance passes five frame wraps.
    for (int k = 1; k <= 1100; k++) q_d.push_back(model_d(k));
    for (int k = 1; k <= 2200; k++) q_s.push_back(model_s(k));
    @(negedge clk) rst_n = 1'b1;
    repeat (4400) @(posedge clk);
    @(negedge clk);
    chk_int("full_drained_1", q_d.size(), 0);
    chk_int("small_drained_1", q_s.size(), 0);

    // Mid-frame reset: outputs must drop to reset values without waiting for a clock.
    rst_n = 1'b0;
    #1;
    chk("full_async_reset", get_d(), RST_OBS);
    chk("small_async_reset", get_s(), RST_OBS);
    q_d.delete();
    q_s.delete();
    repeat (10) @(posedge clk);

    // Run 2: restart from (0,0); small instance covers 61 frames for the blink toggles.
    for (int k = 1; k <= 12975; k++) q_d.push_back(model_d(k));
    for (int k = 1; k <= 25950; k++) q_s.push_back(model_s(k));
    @(negedge clk) rst_n = 1'b1;
    repeat (51900) @(posedge clk);
    @(negedge clk);
    chk_int("full_drained_2", q_d.size(), 0);
    chk_int("small_drained_2", q_s.size(), 0);
    mon_on = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/vga_sync_gen.md
Name: vga_sync_gen

Overview:
- 640x480@60 Hz VGA timing generator; sits directly upstream of the on-screen digit renderers (hour/date number painters).
- Produces the pixel coordinates, video_on and the hsync/vsync pins from the 100 MHz system clock.
- Emits a one-clock frame_start strobe so the RTC snapshot logic and digit-painter state machines can resynchronise once per frame.
- All painters consume pix_x/pix_y/video_on from this block only.

Parameters:
- H_DISPLAY, 640, visible pixels per line
- H_FRONT, 16, horizontal front porch (ticks)
- H_SYNC, 96, hsync pulse width (ticks)
- H_BACK, 48, horizontal back porch (ticks)
- V_DISPLAY, 480, visible lines per frame
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BACK, 33, vertical back porch (lines)
- TICK_DIV, 4, clk cycles per pixel tick (100 MHz -> 25 MHz)

Ports:
- clk  in  1  system clock, 100 MHz
- reset  in  1  asynchronous, active-low reset
- p_tick  out  1  one-clk pulse per pixel period
- pix_x  out  10  current horizontal count, 0..H_TOTAL-1
- pix_y  out  10  current vertical count, 0..V_TOTAL-1
- video_on  out  1  high when pix_x<H_DISPLAY and pix_y<V_DISPLAY
- hsync  out  1  horizontal sync, active low
- vsync  out  1  vertical sync, active low
- frame_start  out  1  one-clk pulse when counters wrap to (0,0)
- blink  out  1  present only with VGA_BLINK_EN

Behaviour:
- Derived constants:
  - H_TOTAL = H_DISPLAY+H_FRONT+H_SYNC+H_BACK = 800
  - V_TOTAL = 525
  - Sync windows: H from 656 to 751 inclusive; V from 490 to 491 inclusive.
- Reset (reset=0, asynchronous assert, synchronous to clk on deassert):
  - tick counter = 0
  - pix_x = 0, pix_y = 0
  - video_on = 1 (consistent with count (0,0))
  - hsync = 1, vsync = 1
  - p_tick = 0, frame_start = 0, blink = 0
- Tick divider:
  - Counter increments each clk and wraps at TICK_DIV-1.
  - p_tick is registered; it is high for exactly the one clk in which the divider value equals TICK_DIV-1.
  - First p_tick is the TICK_DIV-th clk edge after reset release.
- Horizontal counter:
  - On each p_tick clk, pix_x <= pix_x+1.
  - When pix_x==H_TOTAL-1 it wraps to 0 instead.
- Vertical counter:
  - Advances only on the p_tick clk in which pix_x wraps.
  - pix_y == V_TOTAL-1 wraps to 0.
  - No other event changes the counters.
- Registered decodes:
  - video_on, hsync and vsync are computed from the next-count values and updated in the same clk as the counters.
  - They are therefore always aligned with the pix_x/pix_y currently presented; there is zero latency between coordinates and decodes.
  - hsync = 0 iff 656<=pix_x<=751.
  - vsync = 0 iff 490<=pix_y<=491; vsync spans whole lines.
- frame_start: high for one clk, the clk in which the counters transition from (799,524) to (0,0). Never asserted by reset itself.
- Outputs hold stable between p_ticks; there is no glitching, since every output is a flop.
- Widths: counters are 10 bits. H_TOTAL/V_TOTAL must be <=1024; out-of-range parameters are unsupported.
- Reset mid-frame: all state returns to reset values immediately. Timing restarts at (0,0) with no partial frame_start.

Optional Feature:
- Macro: VGA_BLINK_EN.
- Defined:
  - Adds a 5-bit frame counter, incremented on frame_start, wrapping at 29.
  - blink toggles on each wrap: a 30-frame half period, ~0.5 s. Painters use it to flash the digit under edit.
  - Frame counter and blink reset to 0.
- Undefined: the blink port and frame counter are absent; all other behaviour is identical.

Test Plan:
- Reset held low 10 clks, released:
  - pix_x=0, pix_y=0, video_on=1, hsync=1, vsync=1 throughout reset.
  - First p_tick on 4th clk after release.
  - pix_x=1 after it.
- Free-run one line:
  - p_tick spacing is exactly 4 clks.
  - hsync low for exactly 96 ticks, starting when pix_x becomes 656.
  - video_on falls when pix_x becomes 640.
  - pix_x wraps 799->0 and pix_y increments 0->1 in the same clk.
- Free-run one frame (800*525*4 = 1,680,000 clks):
  - vsync low only while pix_y is 490 or 491.
  - video_on low for all pix_y>=480.
  - frame_start asserts exactly once, in the (799,524)->(0,0) clk.
- Reset asserted at pix_x=300, pix_y=200:
  - All outputs return to reset values asynchronously.
  - No frame_start pulse.
  - Timing restarts from (0,0).
- With VGA_BLINK_EN:
  - blink=0 for frames 0..29, toggles to 1 at the 30th frame_start, back to 0 at the 60th.
  - Without the macro, the port is absent and the build is clean.
